// File: rtl/mux3_rr_arbiter_if.sv
// Bundle of the 3-requester arbiter bus: request/data inputs, grant and select
// feedback, and the valid/ready output stage.
// Ports: req[3], din0..din2[DATA_W], gnt[3], sel[2], out_valid, out_ready, dout[DATA_W].
// master = requesters plus downstream consumer; slave = the arbiter.
interface mux3_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [2:0]        gnt;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dout;

    modport master (
        output req, din0, din1, din2, out_ready,
        input  gnt, sel, out_valid, dout
    );

    modport slave (
        input  req, din0, din1, din2, out_ready,
        output gnt, sel, out_valid, dout
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Purpose: round-robin 3:1 arbiter/mux capturing one word into a registered output stage.
// Latency: req seen in IDLE at edge N gives out_valid at cycle N+1; one word per 2 cycles max.
// Backpressure: held word, sel and dout stay frozen while out_ready=0, for any length.
// Ports: clk, rst_n (synchronous, active-low), bus (mux3_rr_arbiter_if.slave),
//        lock (only when MUX3_ARB_LOCK_EN is defined: keeps the round-robin pointer
//        on the completing requester so it wins again next time).
module mux3_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUX3_ARB_LOCK_EN
    input  logic             lock,
`endif
    mux3_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [1:0]        sel_q;
    logic [2:0]        gnt_q;
    logic              vld_q;
    logic [DATA_W-1:0] dout_q;

    logic              hold_ptr;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic              win_vld;
    logic [1:0]        win_idx;
    logic [DATA_W-1:0] win_dat;

`ifdef MUX3_ARB_LOCK_EN
    assign hold_ptr = lock;
`else
    assign hold_ptr = 1'b0;
`endif

    // Modulo-3 increment; the pointer and select never take the value 3.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin search in order ptr, ptr+1, ptr+2.
    always_comb begin
        cand1   = inc3(ptr);
        cand2   = inc3(cand1);
        win_vld = |bus.req;
        win_idx = ptr;
        if (bus.req[ptr]) begin
            win_idx = ptr;
        end else if (bus.req[cand1]) begin
            win_idx = cand1;
        end else begin
            win_idx = cand2;
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_dat = bus.din0;
            2'd1:    win_dat = bus.din1;
            default: win_dat = bus.din2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            sel_q  <= 2'd0;
            gnt_q  <= 3'b000;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            // gnt is a one-cycle pulse: cleared everywhere except the capture edge.
            gnt_q <= 3'b000;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        sel_q  <= win_idx;
                        dout_q <= win_dat;
                        vld_q  <= 1'b1;
                        gnt_q  <= 3'b001 << win_idx;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // sel_q still names the requester being served.
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        ptr   <= hold_ptr ? sel_q : inc3(sel_q);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = vld_q;
    assign bus.dout      = dout_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
module tb_mux3_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic lock;

    mux3_rr_arbiter_if #(.DATA_W(8)) bus ();

    mux3_rr_arbiter #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MUX3_ARB_LOCK_EN
        .lock  (lock),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: transfer-level view of the arbiter.
    bit         m_busy;
    int         m_ptr;
    int         m_sel;
    logic [7:0] m_dout;
    logic [2:0] m_gnt;
    logic       m_vld;
    logic       prev_vld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs about to be sampled.
    task automatic model_update();
        logic [7:0] din_a [3];
        int w;
        bit lk;
        din_a[0] = bus.din0;
        din_a[1] = bus.din1;
        din_a[2] = bus.din2;
`ifdef MUX3_ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_sel = 0;
            m_dout = 8'h00; m_gnt = 3'b000; m_vld = 1'b0;
        end else if (!m_busy) begin
            m_gnt = 3'b000;
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (w < 0 && bus.req[i]) w = i;
            end
            if (w >= 0) begin
                m_busy = 1;
                m_sel  = w;
                m_dout = din_a[w];
                m_vld  = 1'b1;
                m_gnt  = 3'(1 << w);
            end
        end else begin
            m_gnt = 3'b000;
            if (bus.out_ready) begin
                m_busy = 0;
                m_vld  = 1'b0;
                m_ptr  = lk ? m_sel : (m_sel + 1) % 3;
            end
        end
    endtask

    task automatic compare();
        check("gnt",       32'(bus.gnt),       32'(m_gnt));
        check("sel",       32'(bus.sel),       32'(m_sel));
        check("out_valid", 32'(bus.out_valid), 32'(m_vld));
        check("dout",      32'(bus.dout),      32'(m_dout));
        check("sel_not_11", 32'(bus.sel == 2'b11), 0);
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
        check("gnt_first_busy_only",
              32'((bus.gnt != 3'b000) && !(bus.out_valid && !prev_vld)), 0);
        prev_vld = bus.out_valid;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    int vld_cnt;
    int gnt_cnt;

    initial begin
        rst_n = 1'b0; lock = 1'b0;
        bus.req = 3'b000; bus.din0 = 8'h10; bus.din1 = 8'h21; bus.din2 = 8'h32;
        bus.out_ready = 1'b0;
        prev_vld = 1'b0;
        m_busy = 0; m_ptr = 0; m_sel = 0; m_dout = 0; m_gnt = 0; m_vld = 0;
        step();
        step();
        check("rst_gnt",  32'(bus.gnt), 0);
        check("rst_sel",  32'(bus.sel), 0);
        check("rst_vld",  32'(bus.out_valid), 0);
        check("rst_dout", 32'(bus.dout), 0);

        // All three requesting with out_ready held high.
        rst_n = 1'b1; bus.req = 3'b111; bus.out_ready = 1'b1;
        step(); check("rr_gnt0", 32'(bus.gnt), 32'h1); check("rr_sel0", 32'(bus.sel), 0);
        check("rr_dout0", 32'(bus.dout), 32'h10);
        step(); check("rr_gap0", 32'(bus.gnt), 0);
        step(); check("rr_gnt1", 32'(bus.gnt), 32'h2); check("rr_sel1", 32'(bus.sel), 1);
        step(); check("rr_gap1", 32'(bus.gnt), 0);
        step(); check("rr_gnt2", 32'(bus.gnt), 32'h4); check("rr_sel2", 32'(bus.sel), 2);
        step(); check("rr_gap2", 32'(bus.gnt), 0);
        step(); check("rr_gnt3", 32'(bus.gnt), 32'h1); check("rr_sel3", 32'(bus.sel), 0);
        step(); check("rr_done_vld", 32'(bus.out_valid), 0);
        check("rr_sel_kept", 32'(bus.sel), 0);

        // Backpressure: held word must survive input churn.
        bus.req = 3'b010; bus.din1 = 8'hA5; bus.out_ready = 1'b0;
        vld_cnt = 0; gnt_cnt = 0;
        step();
        if (bus.out_valid) vld_cnt++;
        if (bus.gnt != 3'b000) gnt_cnt++;
        check("bp_gnt", 32'(bus.gnt), 32'h2);
        for (int c = 0; c < 5; c++) begin
            bus.req  = 3'($urandom_range(0, 7));
            bus.din1 = 8'($urandom);
            bus.din0 = 8'($urandom);
            step();
            if (bus.out_valid) vld_cnt++;
            if (bus.gnt != 3'b000) gnt_cnt++;
            check("bp_dout", 32'(bus.dout), 32'hA5);
            check("bp_sel",  32'(bus.sel), 1);
        end
        bus.req = 3'b000; bus.out_ready = 1'b1;
        step();
        if (bus.out_valid) vld_cnt++;
        check("bp_vld_cycles", vld_cnt, 6);
        check("bp_gnt_pulses", gnt_cnt, 1);
        check("bp_dout_kept",  32'(bus.dout), 32'hA5);

        // Single requester 2 served every other cycle.
        bus.req = 3'b100; bus.din2 = 8'h5C;
        for (int c = 0; c < 3; c++) begin
            step(); check("r2_gnt", 32'(bus.gnt), 32'h4); check("r2_sel", 32'(bus.sel), 2);
            step(); check("r2_gap", 32'(bus.gnt), 0);   check("r2_sel_kept", 32'(bus.sel), 2);
        end

        // Reset while a word is held.
        bus.req = 3'b001; bus.out_ready = 1'b0;
        step(); step();
        check("mid_busy_vld", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        step();
        check("mr_vld", 32'(bus.out_valid), 0);
        check("mr_sel", 32'(bus.sel), 0);
        check("mr_gnt", 32'(bus.gnt), 0);
        rst_n = 1'b1; bus.req = 3'b110; bus.out_ready = 1'b1;
        step(); check("mr_first_gnt", 32'(bus.gnt), 32'h2);
        step();

`ifdef MUX3_ARB_LOCK_EN
        rst_n = 1'b0; step();
        rst_n = 1'b1; lock = 1'b1; bus.req = 3'b011; bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(); check("lock_gnt0", 32'(bus.gnt), 32'h1);
            if (c == 2) lock = 1'b0;
            step();
        end
        step(); check("unlock_gnt1", 32'(bus.gnt), 32'h2);
        step();
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.req       = 3'($urandom_range(0, 7));
            bus.din0      = 8'($urandom);
            bus.din1      = 8'($urandom);
            bus.din2      = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            lock          = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
